// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and data memory.
// Valid/ready: a beat completes when dmem_req and dmem_ready are both high.
interface load_store_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory transaction per accepted request.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    load_store_unit_if.master dmem
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        FAIL
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        one_op;
    logic        ld_ok;
    logic        st_ok;
    logic        legal;
    logic        misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] byte_sh;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    logic [31:0] ld_ext;

    // Classify the incoming request: exactly one op and a legal width.
    always_comb begin
        one_op = mem_read ^ mem_write;
        unique case (func3)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101: ld_ok = 1'b1;
            default:        ld_ok = 1'b0;
        endcase
        unique case (func3)
            3'b000, 3'b001,
            3'b010:  st_ok = 1'b1;
            default: st_ok = 1'b0;
        endcase
        legal = one_op && (mem_read ? ld_ok : st_ok);
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned = ((func3[1:0] == 2'b01) && addr[0])
                  || ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Byte enables and lane-replicated write data for the request.
    always_comb begin
        unique case (func3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{store_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data;
            end
        endcase
    end

    // Pick the addressed lane of read data and extend it.
    always_comb begin
        byte_sh = dmem.dmem_rdata >> {off_q, 3'b000};
        rd_b    = byte_sh[7:0];
        rd_h    = off_q[1] ? dmem.dmem_rdata[31:16]
                           : dmem.dmem_rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{rd_b[7]}}, rd_b};
            3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h};
            3'b100:  ld_ext = {24'h0, rd_b};
            3'b101:  ld_ext = {16'h0, rd_h};
            default: ld_ext = dmem.dmem_rdata;
        endcase
        cnt_inc = cnt + 8'd1;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            load_data       <= 32'h0;
            cnt             <= 8'h0;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'h0;
            dmem.dmem_be    <= 4'h0;
            dmem.dmem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (legal && !misaligned) begin
                            state           <= REQ;
                            cnt             <= 8'h0;
                            f3_q            <= func3;
                            off_q           <= addr[1:0];
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= mem_write;
                            dmem.dmem_addr  <= {addr[31:2], 2'b00};
                            dmem.dmem_be    <= be_n;
                            dmem.dmem_wdata <= wdata_n;
                        end else begin
                            state <= FAIL;
                            err   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_ready) begin
                        state         <= RESP;
                        done          <= 1'b1;
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_we) begin
                            load_data <= ld_ext;
                        end
                    end else if (cnt_inc == TMO) begin
                        state         <= FAIL;
                        err           <= 1'b1;
                        cnt           <= cnt_inc;
                        dmem.dmem_req <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted data memory.
// The DUT is built with TIMEOUT_CYCLES=4 so the timeout path is short.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    int errors;
    int checks;

    load_store_unit_if bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .func3     (func3),
        .addr      (addr),
        .store_data(store_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .dmem      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        start      = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        func3      = f3;
        addr       = a;
        store_data = sd;
        tick();
        start      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        func3          = 3'b000;
        addr           = 32'h0;
        store_data     = 32'h0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;

        #3;
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_done", done, 1'b0);
        chk1 ("rst_err", err, 1'b0);
        chk1 ("rst_req", bus.dmem_req, 1'b0);
        chk1 ("rst_we", bus.dmem_we, 1'b0);
        chk32("rst_addr", bus.dmem_addr, 32'h0);
        chk32("rst_be", 32'(bus.dmem_be), 32'h0);
        chk32("rst_wdata", bus.dmem_wdata, 32'h0);
        chk32("rst_ld", load_data, 32'h0);
        rst_n = 1'b1;
        tick();
        chk1 ("idle_busy", busy, 1'b0);

        // LW 0x104, zero-wait memory
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
        chk1 ("lw_req", bus.dmem_req, 1'b1);
        chk1 ("lw_we", bus.dmem_we, 1'b0);
        chk32("lw_addr", bus.dmem_addr, 32'h0000_0104);
        chk32("lw_be", 32'(bus.dmem_be), 32'hF);
        chk1 ("lw_busy", busy, 1'b1);
        chk1 ("lw_done_n1", done, 1'b0);
        tick();
        chk1 ("lw_done_n2", done, 1'b1);
        chk1 ("lw_req_drop", bus.dmem_req, 1'b0);
        chk32("lw_data", load_data, 32'hDEADBEEF);
        tick();
        chk1 ("lw_done_pulse", done, 1'b0);
        chk1 ("lw_idle", busy, 1'b0);

        // LB and LBU at 0x203
        bus.dmem_rdata = 32'h80FF_1234;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0);
        chk32("lb_be", 32'(bus.dmem_be), 32'h8);
        chk32("lb_addr", bus.dmem_addr, 32'h0000_0200);
        tick();
        chk32("lb_data", load_data, 32'hFFFF_FF80);
        tick();
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0);
        chk32("lbu_be", 32'(bus.dmem_be), 32'h8);
        tick();
        chk32("lbu_data", load_data, 32'h0000_0080);
        tick();

        // SH 0x302
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD);
        chk1 ("sh_we", bus.dmem_we, 1'b1);
        chk32("sh_be", 32'(bus.dmem_be), 32'hC);
        chk32("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
        chk32("sh_addr", bus.dmem_addr, 32'h0000_0300);
        tick();
        chk1 ("sh_done", done, 1'b1);
        chk32("sh_ld_keep", load_data, 32'h0000_0080);
        tick();

        // SW with ready withheld for three cycles
        bus.dmem_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0408, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            chk1 ("sw_wait_req", bus.dmem_req, 1'b1);
            chk1 ("sw_wait_busy", busy, 1'b1);
            chk1 ("sw_wait_done", done, 1'b0);
            chk32("sw_wait_addr", bus.dmem_addr, 32'h0000_0408);
            chk32("sw_wait_be", 32'(bus.dmem_be), 32'hF);
            chk32("sw_wait_wdata", bus.dmem_wdata, 32'h1234_5678);
            tick();
        end
        bus.dmem_ready = 1'b1;
        chk1 ("sw_req_4th", bus.dmem_req, 1'b1);
        tick();
        chk1 ("sw_done", done, 1'b1);
        chk1 ("sw_err", err, 1'b0);
        tick();

        // Timeout: ready never asserted, TIMEOUT_CYCLES=4
        bus.dmem_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk1 ("tmo_req", bus.dmem_req, 1'b1);
            chk1 ("tmo_err_early", err, 1'b0);
            tick();
        end
        chk1 ("tmo_err", err, 1'b1);
        chk1 ("tmo_req_drop", bus.dmem_req, 1'b0);
        chk1 ("tmo_done", done, 1'b0);
        chk32("tmo_ld_keep", load_data, 32'h0000_0080);
        tick();
        chk1 ("tmo_err_pulse", err, 1'b0);
        chk1 ("tmo_idle", busy, 1'b0);

        // Both qualifiers set
        bus.dmem_ready = 1'b1;
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0600, 32'h0);
        chk1 ("both_err", err, 1'b1);
        chk1 ("both_req", bus.dmem_req, 1'b0);
        chk1 ("both_busy", busy, 1'b1);
        tick();
        chk1 ("both_err_pulse", err, 1'b0);

        // Illegal load func3=011
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0600, 32'h0);
        chk1 ("f3_err", err, 1'b1);
        chk1 ("f3_req", bus.dmem_req, 1'b0);
        tick();

        // Neither qualifier set
        issue(1'b0, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
        chk1 ("none_err", err, 1'b1);
        tick();

        // Asynchronous reset while in REQ
        bus.dmem_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0);
        chk1 ("ar_req_pre", bus.dmem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("ar_req", bus.dmem_req, 1'b0);
        chk1 ("ar_busy", busy, 1'b0);
        chk32("ar_ld", load_data, 32'h0);
        bus.dmem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk1 ("ar_done", done, 1'b0);
        chk1 ("ar_err", err, 1'b0);
        chk1 ("ar_idle", busy, 1'b0);

        // LH at 0x101
        bus.dmem_rdata = 32'h0000_8001;
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk1 ("lh_mis_err", err, 1'b1);
        chk1 ("lh_mis_req", bus.dmem_req, 1'b0);
        tick();
        chk1 ("lh_mis_done", done, 1'b0);
        chk32("lh_mis_ld", load_data, 32'h0);
`else
        chk1 ("lh_req", bus.dmem_req, 1'b1);
        chk32("lh_be", 32'(bus.dmem_be), 32'h3);
        tick();
        chk1 ("lh_done", done, 1'b1);
        chk32("lh_data", load_data, 32'hFFFF_8001);
`endif
        tick();

        // LHU at 0x102, upper half zero-extended
        bus.dmem_rdata = 32'h9ABC_0000;
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0);
        chk32("lhu_be", 32'(bus.dmem_be), 32'hC);
        tick();
        chk32("lhu_data", load_data, 32'h0000_9ABC);
        tick();

        // SB at 0x001: replicated byte, lane 1
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'hCAFE_F00D);
        chk32("sb_be", 32'(bus.dmem_be), 32'h2);
        chk32("sb_wdata", bus.dmem_wdata, 32'h0D0D_0D0D);
        tick();
        chk32("sb_ld_keep", load_data, 32'h0000_9ABC);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
